axil_master_bridge: RTL and testbench
=====================================

Name: axil_master_bridge

Overview:
- Single-outstanding AXI4-Lite master that turns a simple valid/ready command stream into AXI-Lite write or read transactions.
- Sits directly upstream of axilite_reg and drives its s_axi_* slave port, including awport/arport.
- Returns one response per command (BRESP, or RRESP plus RDATA) on a valid/ready response stream.
- Used by the CPU-side sequencer and by block-level benches as the standard register-access master.

Parameters:
- ADDR_WIDTH, 4, AXI address width.
- DATA_WIDTH, 32, AXI data width; must be 32 or 64.
- PROT_DEFAULT, 3'b000, value driven on awport/arport when cmd_prot_ovr=0.

Ports:
- m_axi_aclk  in  1  clock
- m_axi_aresetn  in  1  reset; asynchronous assert, active-low
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write strobes
- cmd_prot_ovr  in  1  1=use cmd_prot, 0=use PROT_DEFAULT
- cmd_prot  in  3  protection override value
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echoes cmd_write
- rsp_resp  out  2  BRESP or RRESP
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- m_axi_awaddr/awvalid/awready/awport, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready  standard AXI-Lite write channels (awport width 3)
- m_axi_araddr/arvalid/arready/arport, m_axi_rdata/rresp/rvalid/rready  standard AXI-Lite read channels (arport width 3)

Behaviour:
- Reset values: all valids, cmd_ready, bready and rready are 0; rsp_* are 0; addr/data/strb/port registers are 0.
- States:
  - IDLE: cmd_ready=1. Accepting a command latches all cmd_* fields. Next state WADDR_DATA for writes, RADDR for reads.
  - WADDR_DATA: awvalid and wvalid are asserted in the same cycle, one cycle after acceptance. Each is dropped independently on its own handshake; AW and W may complete in either order or in the same cycle. When both are done, go to WRESP.
  - WRESP: bready=1. On bvalid, capture bresp and go to RSP.
  - RADDR: arvalid=1 until arready, then go to RDATA.
  - RDATA: rready=1. On rvalid, capture rdata and rresp and go to RSP.
  - RSP: rsp_valid=1, held stable until rsp_ready, then go to IDLE.
- cmd_ready is 0 outside IDLE; only one transaction is outstanding at a time.
- Valid signals never drop before their handshake, and payloads stay stable while valid is high.
- Minimum latency with a zero-wait slave:
  - write: accept at cycle 0, AW/W at 1, B at 2, rsp_valid at 3.
  - read: accept at 0, AR at 1, R at 2, rsp_valid at 3.
- Back-to-back commands: the next cmd is accepted in the cycle after rsp handshake.
- bvalid/rvalid arriving before their address phase completes is a slave protocol error. It is ignored; bready/rready are low in that case.
- Non-OKAY responses are passed through unchanged; the bridge performs no retry.
- Reset mid-transaction: all valids drop immediately (asynchronous), state returns to IDLE, and no response is issued.

Optional Feature:
- Macro AXIL_MASTER_BRIDGE_STATS_EN.
- Defined: adds outputs stat_wr_cnt, stat_rd_cnt and stat_err_cnt, each 16 bits.
  - Counts increment on the rsp handshake; err counts resp != 2'b00.
  - Counters saturate at 16'hFFFF and clear on reset.
  - Input stat_clr (1 bit) synchronously zeroes all three; if stat_clr coincides with an increment, the clear wins.
- Undefined: the stat ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package axil_pkg holds:
  - typedef axi_resp_t (2 bits) and constants RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - typedef axi_prot_t (3 bits);
  - state enum axim_state_t {IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RSP}.
- No sub-module is needed: one FSM plus a datapath register set. The stats counters stay inline.

Test Plan:
- Write 0x4 data 0x0000_BEEF strb 0xF to axilite_reg with zero-wait -> rsp_valid 3 cycles after accept, rsp_resp=00, rsp_write=1. A following read of 0x4 returns rsp_rdata=0x0000_BEEF.
- Slave model delays awready 3 cycles and wready 0 cycles -> wvalid drops after 1 cycle, awvalid is held 4 cycles with awaddr stable, exactly one rsp is produced.
- Slave asserts wready before awready, then both in the same cycle on the next transaction -> both orders complete and bready rises only after both handshakes.
- Read 0xC with rresp=2'b10 injected -> rsp_resp=10 and rsp_rdata equals the slave rdata; with stats enabled, stat_err_cnt=1 and stat_rd_cnt=1.
- rsp_ready held low 5 cycles -> rsp_* stable and cmd_ready=0 throughout; the next command is accepted the cycle after release.
- Deassert m_axi_aresetn while awvalid=1 -> all valids go to 0 without a clock edge, and after reset release cmd_ready=1 with no stray rsp_valid.

Source files
------------

// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI-Lite response/protection types and the bridge state encoding
package axil_pkg;
  typedef logic [1:0] axi_resp_t;
  typedef logic [2:0] axi_prot_t;
  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_EXOKAY = 2'b01;
  localparam axi_resp_t RESP_SLVERR = 2'b10;
  localparam axi_resp_t RESP_DECERR = 2'b11;
  typedef enum logic [2:0] {IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RSP} axim_state_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction
endpackage

// File: rtl/axil_master_bridge_if.sv
// axil_master_bridge_if: AXI4-Lite bus between the bridge (master) and a register slave
interface axil_master_bridge_if import axil_pkg::*; #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  axi_prot_t               awport;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  axi_resp_t               bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  axi_prot_t               arport;
  logic [DATA_WIDTH-1:0]   rdata;
  axi_resp_t               rresp;
  logic                    rvalid;
  logic                    rready;
  modport master (
    output awaddr, awvalid, awport, wdata, wstrb, wvalid, bready, araddr, arvalid, arport, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, awport, wdata, wstrb, wvalid, bready, araddr, arvalid, arport, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_master_bridge.sv
// axil_master_bridge: single-outstanding cmd/rsp to AXI-Lite master; AXIL_MASTER_BRIDGE_STATS_EN adds rsp counters
module axil_master_bridge import axil_pkg::*; #(
  parameter int        ADDR_WIDTH   = 4,
  parameter int        DATA_WIDTH   = 32,
  parameter axi_prot_t PROT_DEFAULT = 3'b000
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  input  logic                    cmd_prot_ovr,
  input  axi_prot_t               cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output axi_resp_t               rsp_resp,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
`ifdef AXIL_MASTER_BRIDGE_STATS_EN
  input  logic                    stat_clr,
  output logic [15:0]             stat_wr_cnt,
  output logic [15:0]             stat_rd_cnt,
  output logic [15:0]             stat_err_cnt,
`endif
  axil_master_bridge_if.master    m_axi
);
  axim_state_t             state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  axi_prot_t               prot_q;
  assign m_axi.awaddr = addr_q;
  assign m_axi.araddr = addr_q;
  assign m_axi.wdata  = wdata_q;
  assign m_axi.wstrb  = wstrb_q;
  assign m_axi.awport = prot_q;
  assign m_axi.arport = prot_q;
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      m_axi.awvalid <= 1'b0;
      m_axi.wvalid  <= 1'b0;
      m_axi.bready  <= 1'b0;
      m_axi.arvalid <= 1'b0;
      m_axi.rready  <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      prot_q        <= '0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_resp      <= '0;
      rsp_rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready     <= 1'b0;
            addr_q        <= cmd_addr;
            wdata_q       <= cmd_wdata;
            wstrb_q       <= cmd_wstrb;
            prot_q        <= cmd_prot_ovr ? cmd_prot : PROT_DEFAULT;
            rsp_write     <= cmd_write;
            m_axi.awvalid <= cmd_write;
            m_axi.wvalid  <= cmd_write;
            m_axi.arvalid <= !cmd_write;
            state         <= cmd_write ? WADDR_DATA : RADDR;
          end
        end
        WADDR_DATA: begin
          // AW and W retire independently; bready waits for both
          if (m_axi.awready) m_axi.awvalid <= 1'b0;
          if (m_axi.wready) m_axi.wvalid <= 1'b0;
          if ((!m_axi.awvalid || m_axi.awready) && (!m_axi.wvalid || m_axi.wready)) begin
            m_axi.bready <= 1'b1;
            state        <= WRESP;
          end
        end
        WRESP: begin
          if (m_axi.bvalid) begin
            m_axi.bready <= 1'b0;
            rsp_resp     <= m_axi.bresp;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RADDR: begin
          if (m_axi.arready) begin
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b1;
            state         <= RDATA;
          end
        end
        RDATA: begin
          if (m_axi.rvalid) begin
            m_axi.rready <= 1'b0;
            rsp_resp     <= m_axi.rresp;
            rsp_rdata    <= m_axi.rdata;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef AXIL_MASTER_BRIDGE_STATS_EN
  logic rsp_fire;
  assign rsp_fire = rsp_valid && rsp_ready;
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn || stat_clr) begin
      stat_wr_cnt  <= '0;
      stat_rd_cnt  <= '0;
      stat_err_cnt <= '0;
    end else begin
      stat_wr_cnt  <= sat_inc(stat_wr_cnt, rsp_fire && rsp_write);
      stat_rd_cnt  <= sat_inc(stat_rd_cnt, rsp_fire && !rsp_write);
      stat_err_cnt <= sat_inc(stat_err_cnt, rsp_fire && rsp_resp != RESP_OKAY);
    end
  end
`endif
endmodule

// File: tb/tb_axil_master_bridge.sv
// tb_axil_master_bridge: directed vector bench with a delay-programmable AXI-Lite slave model
module tb_axil_master_bridge;
  localparam int AW = 4;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0, cmd_prot_ovr = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic [2:0]    cmd_prot = '0;
  logic          cmd_ready, rsp_valid, rsp_write;
  logic [1:0]    rsp_resp;
  logic [DW-1:0] rsp_rdata;
`ifdef AXIL_MASTER_BRIDGE_STATS_EN
  logic          stat_clr = 1'b0;
  logic [15:0]   stat_wr_cnt, stat_rd_cnt, stat_err_cnt;
`endif
  axil_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  axil_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT_DEFAULT(3'b000)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot_ovr(cmd_prot_ovr), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_resp(rsp_resp),
    .rsp_rdata(rsp_rdata),
`ifdef AXIL_MASTER_BRIDGE_STATS_EN
    .stat_clr(stat_clr), .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_err_cnt(stat_err_cnt),
`endif
    .m_axi(bus.master)
  );
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int errors = 0;
  int checks = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // slave model knobs (written by the stimulus process only)
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0] inj_resp = 2'b00;
  // slave observations (written by the slave process only)
  logic [AW-1:0] seen_addr = '0;
  logic [2:0]    seen_prot = '0;
  initial begin
    logic [DW-1:0] mem [4];
    logic p_aw, p_w, p_b, p_ar, p_r, aw_done, w_done, ar_done;
    logic [AW-1:0] sv_waddr, sv_raddr;
    logic [DW-1:0] sv_wdata;
    logic [3:0] sv_wstrb;
    int aw_c, w_c, b_c, ar_c, r_c;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    {p_aw, p_w, p_b, p_ar, p_r, aw_done, w_done, ar_done} = '0;
    {aw_c, w_c, b_c, ar_c, r_c} = '0;
    sv_waddr = '0; sv_raddr = '0; sv_wdata = '0; sv_wstrb = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {p_aw, p_w, p_b, p_ar, p_r, aw_done, w_done, ar_done} = '0;
        {aw_c, w_c, b_c, ar_c, r_c} = '0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
        bus.arready = 1'b0; bus.rvalid = 1'b0;
        continue;
      end
      if (p_aw) begin bus.awready = 1'b0; aw_done = 1'b1; end
      if (p_w) begin bus.wready = 1'b0; w_done = 1'b1; end
      if (p_b) bus.bvalid = 1'b0;
      if (p_ar) begin bus.arready = 1'b0; ar_done = 1'b1; end
      if (p_r) bus.rvalid = 1'b0;
      if (bus.awvalid && !bus.awready && !aw_done) begin
        if (aw_c >= aw_dly) begin
          bus.awready = 1'b1; sv_waddr = bus.awaddr; seen_addr = bus.awaddr; seen_prot = bus.awport; aw_c = 0;
        end else aw_c++;
      end
      if (bus.wvalid && !bus.wready && !w_done) begin
        if (w_c >= w_dly) begin
          bus.wready = 1'b1; sv_wdata = bus.wdata; sv_wstrb = bus.wstrb; w_c = 0;
        end else w_c++;
      end
      if (aw_done && w_done && !bus.bvalid) begin
        if (b_c >= b_dly) begin
          for (int i = 0; i < 4; i++)
            if (sv_wstrb[i]) mem[sv_waddr[3:2]][8*i +: 8] = sv_wdata[8*i +: 8];
          bus.bvalid = 1'b1; bus.bresp = inj_resp; aw_done = 1'b0; w_done = 1'b0; b_c = 0;
        end else b_c++;
      end
      if (bus.arvalid && !bus.arready && !ar_done) begin
        if (ar_c >= ar_dly) begin
          bus.arready = 1'b1; sv_raddr = bus.araddr; seen_addr = bus.araddr; seen_prot = bus.arport; ar_c = 0;
        end else ar_c++;
      end
      if (ar_done && !bus.rvalid) begin
        if (r_c >= r_dly) begin
          bus.rvalid = 1'b1; bus.rdata = mem[sv_raddr[3:2]]; bus.rresp = inj_resp; ar_done = 1'b0; r_c = 0;
        end else r_c++;
      end
      p_aw = bus.awvalid && bus.awready;
      p_w  = bus.wvalid && bus.wready;
      p_b  = bus.bvalid && bus.bready;
      p_ar = bus.arvalid && bus.arready;
      p_r  = bus.rvalid && bus.rready;
    end
  end
  typedef struct {
    logic wr; logic [3:0] addr; logic [31:0] wdata; logic [3:0] strb; logic povr; logic [2:0] prot;
    int aw_d; int w_d; int ar_d; int b_d; int r_d; logic [1:0] resp; int hold;
    int lat; int awv; int wv; logic [31:0] rdata; logic [2:0] eprot;
  } vec_t;
  task automatic run(input vec_t v, input string tag);
    int n, a, awv, wv;
    logic stab_bad, ord_bad;
    logic [AW-1:0] aw_first;
    logic [36:0] snap;
    aw_dly = v.aw_d; w_dly = v.w_d; ar_dly = v.ar_d; b_dly = v.b_d; r_dly = v.r_d; inj_resp = v.resp;
    @(negedge clk);
    cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.strb;
    cmd_prot_ovr = v.povr; cmd_prot = v.prot; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      chk({tag, " accept_timeout"}, 1'b1, 1'b0);
      cmd_valid = 1'b0;
      return;
    end
    a = cyc; awv = 0; wv = 0; stab_bad = 1'b0; ord_bad = 1'b0; aw_first = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({tag, " busy_cmd_ready"}, cmd_ready, 1'b0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      if (bus.awvalid) begin
        if (awv == 0) aw_first = bus.awaddr;
        else if (bus.awaddr !== aw_first) stab_bad = 1'b1;
        awv++;
      end
      if (bus.wvalid) wv++;
      if (bus.bready && (bus.awvalid || bus.wvalid)) ord_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      chk({tag, " rsp_timeout"}, 1'b1, 1'b0);
      return;
    end
    chk({tag, " latency"}, cyc - a, v.lat);
    chk({tag, " rsp_write"}, rsp_write, v.wr);
    chk({tag, " rsp_resp"}, rsp_resp, v.resp);
    chk({tag, " rsp_rdata"}, rsp_rdata, v.rdata);
    chk({tag, " bus_addr"}, seen_addr, v.addr);
    chk({tag, " bus_prot"}, seen_prot, v.eprot);
    if (v.wr) begin
      chk({tag, " awvalid_cycles"}, awv, v.awv);
      chk({tag, " wvalid_cycles"}, wv, v.wv);
      chk({tag, " awaddr_stable"}, stab_bad, 1'b0);
      chk({tag, " bready_after_aw_w"}, ord_bad, 1'b0);
    end
    snap = {rsp_valid, rsp_write, rsp_resp, rsp_rdata};
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk({tag, " rsp_hold_stable"}, {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, snap);
      chk({tag, " rsp_hold_cmd_ready"}, cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, " rsp_valid_drop"}, rsp_valid, 1'b0);
    chk({tag, " next_cmd_ready"}, cmd_ready, 1'b1);
  endtask
  vec_t vecs [11];
  initial begin
    vecs[0]  = '{1'b1, 4'h4, 32'h0000BEEF, 4'hF, 1'b0, 3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 3, 1, 1, 32'h0, 3'd0};
    vecs[1]  = '{1'b0, 4'h4, 32'h0,        4'h0, 1'b0, 3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 3, 0, 0, 32'h0000BEEF, 3'd0};
    vecs[2]  = '{1'b1, 4'h8, 32'h12345678, 4'hF, 1'b0, 3'd0, 3, 0, 0, 0, 0, 2'b00, 0, 6, 4, 1, 32'h0, 3'd0};
    vecs[3]  = '{1'b1, 4'h0, 32'hA5A5A5A5, 4'h3, 1'b1, 3'd5, 0, 2, 0, 0, 0, 2'b00, 0, 5, 1, 3, 32'h0, 3'd5};
    vecs[4]  = '{1'b0, 4'h0, 32'h0,        4'h0, 1'b1, 3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 3, 0, 0, 32'h0000A5A5, 3'd2};
    vecs[5]  = '{1'b1, 4'hC, 32'hCAFEF00D, 4'hF, 1'b0, 3'd0, 1, 1, 0, 0, 0, 2'b00, 0, 4, 2, 2, 32'h0, 3'd0};
    vecs[6]  = '{1'b0, 4'hC, 32'h0,        4'h0, 1'b0, 3'd7, 0, 0, 0, 0, 0, 2'b10, 0, 3, 0, 0, 32'hCAFEF00D, 3'd0};
    vecs[7]  = '{1'b0, 4'h8, 32'h0,        4'h0, 1'b0, 3'd0, 0, 0, 2, 0, 1, 2'b00, 0, 6, 0, 0, 32'h12345678, 3'd0};
    vecs[8]  = '{1'b1, 4'h4, 32'hFFFFFFFF, 4'h0, 1'b0, 3'd0, 0, 0, 0, 2, 0, 2'b11, 0, 5, 1, 1, 32'h0, 3'd0};
    vecs[9]  = '{1'b0, 4'h4, 32'h0,        4'h0, 1'b0, 3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 3, 0, 0, 32'h0000BEEF, 3'd0};
    vecs[10] = '{1'b1, 4'h8, 32'h0F0F0F0F, 4'hF, 1'b0, 3'd0, 0, 0, 0, 0, 0, 2'b00, 5, 3, 1, 1, 32'h0, 3'd0};
    repeat (3) @(negedge clk);
    chk("reset cmd_ready", cmd_ready, 1'b0);
    chk("reset valids", {bus.awvalid, bus.wvalid, bus.arvalid, rsp_valid}, 4'b0000);
    chk("reset readies", {bus.bready, bus.rready}, 2'b00);
    chk("reset payload", {bus.awaddr, bus.wdata, bus.wstrb, bus.awport}, 43'h0);
    chk("reset rsp", {rsp_write, rsp_resp, rsp_rdata}, 35'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle cmd_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 11; i++) run(vecs[i], $sformatf("vec%0d", i));
`ifdef AXIL_MASTER_BRIDGE_STATS_EN
    chk("stat_wr_cnt", stat_wr_cnt, 16'd6);
    chk("stat_rd_cnt", stat_rd_cnt, 16'd5);
    chk("stat_err_cnt", stat_err_cnt, 16'd2);
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    chk("stat_clr", {stat_wr_cnt, stat_rd_cnt, stat_err_cnt}, 48'h0);
`endif
    // reset while the write address phase is stalled
    aw_dly = 5; w_dly = 5; inj_resp = 2'b00;
    @(negedge clk);
    cmd_write = 1'b1; cmd_addr = 4'h0; cmd_wdata = 32'h11111111; cmd_wstrb = 4'hF; cmd_prot_ovr = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset awvalid", {bus.awvalid, bus.wvalid}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset valids", {bus.awvalid, bus.wvalid, bus.arvalid, rsp_valid}, 4'b0000);
    chk("async reset readies", {cmd_ready, bus.bready, bus.rready}, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset cmd_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset no rsp", rsp_valid, 1'b0);
    end
    run(vecs[9], "post_reset_read");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
